// File: rtl/stp_pkg.sv
// Shared types and constants for the stopwatch timebase.
package stp_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2
    } state_t;

    localparam int SEC_MAX = 59;
    localparam int MIN_MAX = 59;
    localparam int SEC_W   = 6;
    localparam int MIN_W   = 6;

    // Width of a counter spanning 0..n-1, never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/stp_mod_counter.sv
// Modulo-MOD counter link of the timebase chain; carry fires on the wrapping increment.
module stp_mod_counter #(
    parameter int MOD = 60,
    parameter int W   = 6
) (
    input  logic         CLK,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         inc,
    input  logic         hold,
    output logic [W-1:0] cnt,
    output logic         carry
);

    localparam logic [W-1:0] LAST = W'(MOD - 1);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    assign carry = inc & (cnt_q == LAST);
    assign cnt   = cnt_q;

    // hold freezes the whole chain when the maximum time is reached.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && !hold) begin
            cnt_d = (cnt_q == LAST) ? '0 : cnt_q + W'(1);
        end
    end

    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/stp_timebase_chain.sv
// Stopwatch timebase: prescaler, sub/sec/min/hour chain and run/pause FSM.
// Optional lap capture registers are built when STP_LAP_CAPTURE_EN is defined.
module stp_timebase_chain
    import stp_pkg::*;
#(
    parameter int  CLK_HZ   = 1000,
    parameter int  SUB_HZ   = 100,
    parameter int  HOUR_MAX = 100,
    localparam int SUB_W    = cnt_width(SUB_HZ),
    localparam int HR_W     = cnt_width(HOUR_MAX)
) (
    input  logic             CLK,
    input  logic             rst_n,
    input  logic             start_stop,
    input  logic             clear,
    input  logic             lap,
    output logic             running,
    output logic [SUB_W-1:0] sub,
    output logic [5:0]       sec,
    output logic [5:0]       min,
    output logic [HR_W-1:0]  hour,
    output logic             sec_tick,
    output logic             min_tick,
    output logic             ovf,
    output logic             lap_valid,
    output logic [SUB_W-1:0] lap_sub,
    output logic [5:0]       lap_sec,
    output logic [5:0]       lap_min,
    output logic [HR_W-1:0]  lap_hour
);

    localparam int DIV = CLK_HZ / SUB_HZ;
    localparam int PW  = cnt_width(DIV);
    localparam logic [PW-1:0] PRESC_LAST = PW'(DIV - 1);

    state_t        state_q, state_d;
    logic [PW-1:0] presc_q, presc_d;
    logic          ovf_q, ovf_d;

    logic sub_tick;
    logic hr_tick;
    logic max_hit;

    assign sub_tick = (state_q == ST_RUN) && (presc_q == PRESC_LAST);
    assign running  = (state_q == ST_RUN);
    assign ovf      = ovf_q;

    always_comb begin
        presc_d = presc_q;
        if (clear) begin
            presc_d = '0;
        end else if (state_q == ST_RUN) begin
            presc_d = (presc_q == PRESC_LAST) ? '0 : presc_q + PW'(1);
        end
    end

    // Reaching the maximum beats start_stop: the run is stopped regardless.
    always_comb begin
        state_d = state_q;
        ovf_d   = ovf_q;
        if (clear) begin
            state_d = ST_IDLE;
            ovf_d   = 1'b0;
        end else if (max_hit) begin
            state_d = ST_PAUSE;
            ovf_d   = 1'b1;
        end else if (start_stop) begin
            case (state_q)
                ST_IDLE:  state_d = ST_RUN;
                ST_RUN:   state_d = ST_PAUSE;
                ST_PAUSE: state_d = ovf_q ? ST_PAUSE : ST_RUN;
                default:  state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            presc_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            presc_q <= presc_d;
            ovf_q   <= ovf_d;
        end
    end

    stp_mod_counter #(.MOD(SUB_HZ), .W(SUB_W)) u_sub (
        .CLK(CLK), .rst_n(rst_n), .clr(clear), .inc(sub_tick), .hold(max_hit),
        .cnt(sub), .carry(sec_tick)
    );

    stp_mod_counter #(.MOD(SEC_MAX + 1), .W(SEC_W)) u_sec (
        .CLK(CLK), .rst_n(rst_n), .clr(clear), .inc(sec_tick), .hold(max_hit),
        .cnt(sec), .carry(min_tick)
    );

    stp_mod_counter #(.MOD(MIN_MAX + 1), .W(MIN_W)) u_min (
        .CLK(CLK), .rst_n(rst_n), .clr(clear), .inc(min_tick), .hold(max_hit),
        .cnt(min), .carry(hr_tick)
    );

    // The hour carry is the wrap past HOUR_MAX-1:59:59, i.e. the maximum time.
    stp_mod_counter #(.MOD(HOUR_MAX), .W(HR_W)) u_hour (
        .CLK(CLK), .rst_n(rst_n), .clr(clear), .inc(hr_tick), .hold(max_hit),
        .cnt(hour), .carry(max_hit)
    );

`ifdef STP_LAP_CAPTURE_EN
    logic             lap_valid_q, lap_valid_d;
    logic [SUB_W-1:0] lap_sub_q, lap_sub_d;
    logic [5:0]       lap_sec_q, lap_sec_d;
    logic [5:0]       lap_min_q, lap_min_d;
    logic [HR_W-1:0]  lap_hour_q, lap_hour_d;

    // Capture reads the counter outputs, so a same-cycle update is not seen.
    always_comb begin
        lap_valid_d = lap_valid_q;
        lap_sub_d   = lap_sub_q;
        lap_sec_d   = lap_sec_q;
        lap_min_d   = lap_min_q;
        lap_hour_d  = lap_hour_q;
        if (clear) begin
            lap_valid_d = 1'b0;
        end else if (lap && (state_q != ST_IDLE)) begin
            lap_valid_d = 1'b1;
            lap_sub_d   = sub;
            lap_sec_d   = sec;
            lap_min_d   = min;
            lap_hour_d  = hour;
        end
    end

    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            lap_valid_q <= 1'b0;
            lap_sub_q   <= '0;
            lap_sec_q   <= '0;
            lap_min_q   <= '0;
            lap_hour_q  <= '0;
        end else begin
            lap_valid_q <= lap_valid_d;
            lap_sub_q   <= lap_sub_d;
            lap_sec_q   <= lap_sec_d;
            lap_min_q   <= lap_min_d;
            lap_hour_q  <= lap_hour_d;
        end
    end

    assign lap_valid = lap_valid_q;
    assign lap_sub   = lap_sub_q;
    assign lap_sec   = lap_sec_q;
    assign lap_min   = lap_min_q;
    assign lap_hour  = lap_hour_q;
`else
    logic unused_lap;
    assign unused_lap = lap;

    assign lap_valid = 1'b0;
    assign lap_sub   = '0;
    assign lap_sec   = '0;
    assign lap_min   = '0;
    assign lap_hour  = '0;
`endif

endmodule
